// File: rtl/ddc_acq_ctrl.sv
// Sequences the ddc: activate/decimation strobes, CIC settle discard, qualified capture count.
// Latency: ddc_val_i to capture_o and start_i to err_o are 1 cycle. No backpressure: ddc_val_i is never stalled.
module ddc_acq_ctrl #(
  parameter int RATE_WIDTH   = 16,
  parameter int CNT_WIDTH    = 24,
  parameter int CIC_MAXRATE  = 50,
  parameter int SETTLE_COUNT = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic [CNT_WIDTH-1:0]  nsamples_i,
  input  logic                  ddc_val_i,
  output logic                  act_o,
  output logic                  act_out_o,
  output logic                  capture_o,
  output logic [CNT_WIDTH-1:0]  sample_cnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int SW = $clog2(SETTLE_COUNT + 1);
  localparam logic [RATE_WIDTH-1:0] RATE_MIN    = RATE_WIDTH'(2);
  localparam logic [RATE_WIDTH-1:0] RATE_MAX    = RATE_WIDTH'(CIC_MAXRATE);
  localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE} state_t;

  state_t                state_q, state_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [CNT_WIDTH-1:0]  nsamp_q, nsamp_d;
  logic [RATE_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                  act_out_q, act_out_d;
  logic                  capture_q, capture_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rate_ok;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rate_q    <= '0;
      nsamp_q   <= '0;
      dec_cnt_q <= '0;
      settle_q  <= '0;
      cnt_q     <= '0;
      act_out_q <= 1'b0;
      capture_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      nsamp_q   <= nsamp_d;
      dec_cnt_q <= dec_cnt_d;
      settle_q  <= settle_d;
      cnt_q     <= cnt_d;
      act_out_q <= act_out_d;
      capture_q <= capture_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    nsamp_d   = nsamp_q;
    dec_cnt_d = dec_cnt_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    act_out_d = 1'b0;
    capture_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = cnt_q + CNT_WIDTH'(1);
    rate_ok   = (rate_i >= RATE_MIN) && (rate_i <= RATE_MAX);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (rate_ok) begin
            rate_d    = rate_i;
            nsamp_d   = nsamples_i;
            dec_cnt_d = '0;
            settle_d  = '0;
            cnt_d     = '0;
            state_d   = SETTLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (ddc_val_i) begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SETTLE_LAST) state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (ddc_val_i) begin
          capture_d = 1'b1;
          cnt_d     = cnt_inc;
          if ((nsamp_q != '0) && (cnt_inc == nsamp_q)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobe only while staying active, so it drops on the same edge as stop/done.
    if ((state_q != IDLE) && (state_d != IDLE)) begin
      act_out_d = (dec_cnt_q == (rate_q - RATE_WIDTH'(1)));
      dec_cnt_d = act_out_d ? '0 : dec_cnt_q + RATE_WIDTH'(1);
    end
  end

  assign act_o        = (state_q != IDLE);
  assign busy_o       = (state_q != IDLE);
  assign act_out_o    = act_out_q;
  assign capture_o    = capture_q;
  assign sample_cnt_o = cnt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
